// File: rtl/data_mem_if.sv
// Bus between the datapath and the data memory: address, store data and op in,
// load data and error flag out.
interface data_mem_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [2:0]  mem_op;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        err;

  modport master (output addr, wdata, we, mem_op, pc, input rdata, err);
  modport slave  (input addr, wdata, we, mem_op, pc, output rdata, err);
endinterface

// File: rtl/data_mem.sv
// Word-organised MIPS data memory: byte-merging stores, extending loads, error flag.
// Optional store trace enabled by defining DATA_MEM_TRACE_EN.
module data_mem #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  data_mem_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    OP_WORD = 3'b000,
    OP_HU   = 3'b001,
    OP_H    = 3'b010,
    OP_BU   = 3'b011,
    OP_B    = 3'b100
  } mem_op_e;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] widx;
  logic                  in_range;
  logic                  is_word;
  logic                  is_half;
  logic                  is_byte;
  logic                  is_signed;
  logic                  illegal;
  logic [31:0]           old_word;
  logic [31:0]           new_word;
  logic [15:0]           half_sel;
  logic [7:0]            byte_sel;
  logic [4:0]            lane_lsb;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    widx      = bus.addr[ADDR_WIDTH+1:2];
    in_range  = (bus.addr[31:ADDR_WIDTH+2] == '0);
    lane_lsb  = {bus.addr[1:0], 3'b000};
    is_word   = 1'b0;
    is_half   = 1'b0;
    is_byte   = 1'b0;
    is_signed = 1'b0;
    illegal   = 1'b0;
    case (mem_op_e'(bus.mem_op))
      OP_WORD: is_word = 1'b1;
      OP_HU:   is_half = 1'b1;
      OP_H:    begin is_half = 1'b1; is_signed = 1'b1; end
      OP_BU:   is_byte = 1'b1;
      OP_B:    begin is_byte = 1'b1; is_signed = 1'b1; end
      default: illegal = 1'b1;
    endcase

    bus.err = !in_range || illegal
            || (is_word && (bus.addr[1:0] != 2'b00))
            || (is_half && bus.addr[0]);

    old_word = mem[widx];
    half_sel = bus.addr[1] ? old_word[31:16] : old_word[15:0];
    byte_sel = old_word[lane_lsb +: 8];

    bus.rdata = 32'h0;
    if (!bus.err) begin
      if (is_word)
        bus.rdata = old_word;
      else if (is_half)
        bus.rdata = {{16{is_signed & half_sel[15]}}, half_sel};
      else
        bus.rdata = {{24{is_signed & byte_sel[7]}}, byte_sel};
    end

    // Store merge: untouched lanes keep the current word contents.
    new_word = old_word;
    if (is_word)
      new_word = bus.wdata;
    else if (is_half) begin
      if (bus.addr[1]) new_word[31:16] = bus.wdata[15:0];
      else             new_word[15:0]  = bus.wdata[15:0];
    end else if (is_byte)
      new_word[lane_lsb +: 8] = bus.wdata[7:0];
  end

  // NOTE: the array is cleared by reset on purpose, so a post-reset load is defined as zero;
  // state updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 32'h0;
    end else if (bus.we && !bus.err) begin
      mem[widx] <= new_word;
`ifdef DATA_MEM_TRACE_EN
      $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, new_word);
`endif
    end
  end

`ifndef DATA_MEM_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif

endmodule
